// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - Load unit: unaligned byte/half/word/dword loads over a 64-bit beat port
//
// Ports:
//   clk, rst                       single clock, synchronous active-high reset
//   ld_valid/ld_ready              load request handshake (ready only when idle)
//   ld_addr/ld_size/ld_unsigned/ld_rd  request fields captured on accept
//   mem_req/mem_addr/mem_gnt       beat read request, held until granted
//   mem_rvalid/mem_rdata/mem_err   beat read response
//   wb_valid/wb_ready              writeback handshake
//   wb_rd/wb_data/wb_err           writeback result, held until consumed
module mem_load_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [4:0]        ld_rd,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [63:0]       wb_data,
  output logic              wb_err
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            r_state;
  logic [2:0]        r_off;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [4:0]        r_rd;
  logic [63:0]       r_beat0;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_wb_valid;
  logic [63:0]       r_wb_data;
  logic              r_wb_err;

  logic [3:0]        w_bytes;
  logic              w_cross;

  // Access spills into the next beat when it runs past byte 7 of the first.
  assign w_bytes = 4'd1 << r_size;
  assign w_cross = ({1'b0, r_off} + w_bytes) > 4'd8;

  // Shift the two-beat window down to the access offset, then extend by size.
  function automatic logic [63:0] f_extract(input logic [127:0] cat, input logic [2:0] off,
                                            input logic [1:0] size, input logic uns);
    logic [127:0] sh;
    logic [63:0]  res;
    sh = cat >> {off, 3'b000};
    case (size)
      2'd0:    res = uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    res = uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    res = uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: res = sh[63:0];
    endcase
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_off      <= 3'b0;
      r_size     <= 2'b0;
      r_unsigned <= 1'b0;
      r_rd       <= 5'b0;
      r_beat0    <= 64'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= 64'b0;
      r_wb_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld_valid) begin
            r_off      <= ld_addr[2:0];
            r_size     <= ld_size;
            r_unsigned <= ld_unsigned;
            r_rd       <= ld_rd;
            r_mem_addr <= {ld_addr[ADDR_W-1:3], 3'b000};
            r_mem_req  <= 1'b1;
            r_state    <= REQ0;
          end
        end
        REQ0: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            if (mem_err) begin
              r_wb_err   <= 1'b1;
              r_wb_data  <= 64'b0;
              r_wb_valid <= 1'b1;
              r_state    <= RESP;
            end else if (w_cross) begin
              r_beat0    <= mem_rdata;
              r_mem_addr <= r_mem_addr + ADDR_W'(8);  // wraps at the top of the address space
              r_mem_req  <= 1'b1;
              r_state    <= REQ1;
            end else begin
              r_wb_err   <= 1'b0;
              r_wb_data  <= f_extract({64'b0, mem_rdata}, r_off, r_size, r_unsigned);
              r_wb_valid <= 1'b1;
              r_state    <= RESP;
            end
          end
        end
        REQ1: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            r_wb_err   <= mem_err;
            r_wb_data  <= mem_err ? 64'b0
                                  : f_extract({mem_rdata, r_beat0}, r_off, r_size, r_unsigned);
            r_wb_valid <= 1'b1;
            r_state    <= RESP;
          end
        end
        RESP: begin
          if (wb_ready) begin
            r_wb_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ld_ready = (r_state == IDLE);
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_rd;
  assign wb_data  = r_wb_data;
  assign wb_err   = r_wb_err;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - Directed self-checking bench for mem_load_unit
module tb_mem_load_unit;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [63:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [4:0]  ld_rd;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_err;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_err;

  int checks   = 0;
  int failures = 0;

  mem_load_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .ld_rd(ld_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one load and plays a memory that grants after gdly waiting cycles and
  // returns data the cycle after each grant; wb_ready comes after rdly cycles.
  task automatic do_load(input logic [63:0] addr, input logic [1:0] size, input logic uns,
                         input logic [4:0] rd, input logic [63:0] b0, input logic [63:0] b1,
                         input logic e0, input logic e1, input int gdly, input int rdly,
                         output int lat, output logic [63:0] data, output logic err,
                         output logic [4:0] rdo, output int nreq, output logic [63:0] a0,
                         output logic [63:0] a1, output logic stable, output logic to);
    int c, gw, rw, beat_idx;
    logic resp_due, done, done_next;
    logic [63:0] held;
    lat = -1; data = '0; err = 1'b0; rdo = '0; nreq = 0; a0 = '1; a1 = '1;
    stable = 1'b1; held = '0;
    gw = 0; rw = 0; beat_idx = 0; resp_due = 1'b0; done = 1'b0; done_next = 1'b0;
    if (ld_ready !== 1'b1) stable = 1'b0;
    ld_addr = addr; ld_size = size; ld_unsigned = uns; ld_rd = rd; ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    c = 1;
    while (!done && c < 200) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; wb_ready = 1'b0;
      if (resp_due) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (beat_idx == 0) ? b0 : b1;
        mem_err    = (beat_idx == 0) ? e0 : e1;
        resp_due   = 1'b0;
        beat_idx++;
      end else begin
        mem_err = 1'b0;
      end
      if (ld_ready !== 1'b0) stable = 1'b0;
      if (mem_req === 1'b1) begin
        if (gw == 0) begin
          nreq++;
          if (nreq == 1) a0 = mem_addr; else a1 = mem_addr;
          held = mem_addr;
        end else if (mem_addr !== held) begin
          stable = 1'b0;
        end
        if (gw == gdly) begin mem_gnt = 1'b1; gw = 0; resp_due = 1'b1; end
        else gw++;
      end
      if (wb_valid === 1'b1) begin
        if (rw == 0) begin
          lat = c; data = wb_data; err = wb_err; rdo = wb_rd;
        end else if (wb_data !== data || wb_err !== err || wb_rd !== rdo) begin
          stable = 1'b0;
        end
        if (rw == rdly) begin wb_ready = 1'b1; done_next = 1'b1; end
        else rw++;
      end
      step();
      c++;
      if (done_next) done = 1'b1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; wb_ready = 1'b0; mem_err = 1'b0;
    to = !done;
    if (done && (wb_valid !== 1'b0 || ld_ready !== 1'b1)) stable = 1'b0;
  endtask

  int lat, nreq;
  logic [63:0] data, a0, a1;
  logic err, stable, to;
  logic [4:0] rdo;

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready actual=%b required=1", ld_ready); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req actual=%b required=0", mem_req); end
    checks++; if (mem_addr !== 64'h0) begin failures++; $display("FAIL reset_mem_addr actual=%h required=0", mem_addr); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid actual=%b required=0", wb_valid); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_wb_err actual=%b required=0", wb_err); end
    checks++; if (wb_data !== 64'h0) begin failures++; $display("FAIL reset_wb_data actual=%h required=0", wb_data); end
    checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL reset_wb_rd actual=%0d required=0", wb_rd); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_word_signed();
    do_load(64'h1004, 2'd2, 1'b0, 5'd3, 64'h80000001_00000000, 64'h0, 1'b0, 1'b0, 0, 0,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL word_timeout actual=%b required=0", to); end
    checks++; if (data !== 64'hFFFFFFFF80000001) begin failures++; $display("FAIL word_data actual=%h required=ffffffff80000001", data); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL word_latency actual=%0d required=3", lat); end
    checks++; if (nreq !== 1) begin failures++; $display("FAIL word_nreq actual=%0d required=1", nreq); end
    checks++; if (a0 !== 64'h1000) begin failures++; $display("FAIL word_addr actual=%h required=1000", a0); end
    checks++; if (rdo !== 5'd3 || err !== 1'b0) begin failures++; $display("FAIL word_rd_err actual=%0d/%b required=3/0", rdo, err); end
  endtask

  task automatic test_half_cross();
    do_load(64'h1007, 2'd1, 1'b1, 5'd9, 64'hAB000000_00000000, 64'h00000000_000000CD, 1'b0, 1'b0, 0, 0,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL half_timeout actual=%b required=0", to); end
    checks++; if (data !== 64'hCDAB) begin failures++; $display("FAIL half_data actual=%h required=cdab", data); end
    checks++; if (nreq !== 2) begin failures++; $display("FAIL half_nreq actual=%0d required=2", nreq); end
    checks++; if (a0 !== 64'h1000 || a1 !== 64'h1008) begin failures++; $display("FAIL half_addrs actual=%h,%h required=1000,1008", a0, a1); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL half_latency actual=%0d required=5", lat); end
  endtask

  task automatic test_byte();
    do_load(64'h2003, 2'd0, 1'b0, 5'd1, 64'h00000000_80000000, 64'h0, 1'b0, 1'b0, 0, 0,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (data !== 64'hFFFFFFFFFFFFFF80 || to) begin failures++; $display("FAIL byte_signed actual=%h required=ffffffffffffff80", data); end
    do_load(64'h2003, 2'd0, 1'b1, 5'd1, 64'h00000000_80000000, 64'h0, 1'b0, 1'b0, 0, 0,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (data !== 64'h80 || to) begin failures++; $display("FAIL byte_unsigned actual=%h required=80", data); end
  endtask

  task automatic test_backpressure();
    do_load(64'h1004, 2'd2, 1'b0, 5'd12, 64'h80000001_00000000, 64'h0, 1'b0, 1'b0, 4, 3,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL bp_timeout actual=%b required=0", to); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_stable actual=%b required=1", stable); end
    checks++; if (lat !== 7) begin failures++; $display("FAIL bp_latency actual=%0d required=7", lat); end
    checks++; if (data !== 64'hFFFFFFFF80000001 || rdo !== 5'd12) begin failures++; $display("FAIL bp_result actual=%h/%0d required=ffffffff80000001/12", data, rdo); end
    checks++; if (nreq !== 1) begin failures++; $display("FAIL bp_nreq actual=%0d required=1", nreq); end
  endtask

  task automatic test_errors();
    do_load(64'h3004, 2'd3, 1'b0, 5'd4, 64'h11223344_55667788, 64'h99AABBCC_DDEEFF00, 1'b1, 1'b0, 0, 0,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (nreq !== 1 || to) begin failures++; $display("FAIL err0_nreq actual=%0d required=1", nreq); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err0_flag actual=%b required=1", err); end
    checks++; if (data !== 64'h0) begin failures++; $display("FAIL err0_data actual=%h required=0", data); end
    do_load(64'h1007, 2'd1, 1'b1, 5'd5, 64'hAB000000_00000000, 64'hCD, 1'b0, 1'b1, 0, 0,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (nreq !== 2 || err !== 1'b1 || data !== 64'h0 || to) begin failures++; $display("FAIL err1_result actual=%0d/%b/%h required=2/1/0", nreq, err, data); end
  endtask

  task automatic test_boundaries();
    do_load(64'hFFFFFFFFFFFFFFFF, 2'd1, 1'b0, 5'd0, 64'h5A000000_00000000, 64'h00000000_00000081, 1'b0, 1'b0, 0, 0,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (a0 !== 64'hFFFFFFFFFFFFFFF8 || a1 !== 64'h0 || to) begin failures++; $display("FAIL wrap_addrs actual=%h,%h required=fffffffffffffff8,0", a0, a1); end
    checks++; if (data !== 64'hFFFFFFFFFFFF815A || rdo !== 5'd0) begin failures++; $display("FAIL wrap_data actual=%h/%0d required=ffffffffffff815a/0", data, rdo); end
    do_load(64'h4000, 2'd3, 1'b1, 5'd31, 64'hFEDCBA98_76543210, 64'h0, 1'b0, 1'b0, 0, 0,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (data !== 64'hFEDCBA9876543210 || nreq !== 1 || lat !== 3 || to) begin failures++; $display("FAIL dword_aligned actual=%h/%0d/%0d required=fedcba9876543210/1/3", data, nreq, lat); end
    do_load(64'h5006, 2'd1, 1'b0, 5'd2, 64'h8001FFFF_FFFFFFFF, 64'h0, 1'b0, 1'b0, 0, 0,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (data !== 64'hFFFFFFFFFFFF8001 || nreq !== 1 || to) begin failures++; $display("FAIL half_top_edge actual=%h/%0d required=ffffffffffff8001/1", data, nreq); end
  endtask

  task automatic test_reset_mid();
    ld_addr = 64'h1004; ld_size = 2'd2; ld_unsigned = 1'b0; ld_rd = 5'd7; ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h7FFFFFFF_00000000; mem_err = 1'b0;
    checks++; if (ld_ready !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_idle actual=%b/%b required=1/0", ld_ready, mem_req); end
    step();
    mem_rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b0 || ld_ready !== 1'b1) begin failures++; $display("FAIL rstmid_late_rvalid actual=%b/%b required=0/1", wb_valid, ld_ready); end
    step();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_wb actual=%b required=0", wb_valid); end
    do_load(64'h1004, 2'd2, 1'b0, 5'd8, 64'h80000001_00000000, 64'h0, 1'b0, 1'b0, 0, 0,
            lat, data, err, rdo, nreq, a0, a1, stable, to);
    checks++; if (data !== 64'hFFFFFFFF80000001 || rdo !== 5'd8 || lat !== 3 || to) begin failures++; $display("FAIL rstmid_next_load actual=%h/%0d/%0d required=ffffffff80000001/8/3", data, rdo, lat); end
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_size = '0; ld_unsigned = 1'b0; ld_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0; wb_ready = 1'b0;
    test_reset();
    test_word_signed();
    test_half_cross();
    test_byte();
    test_backpressure();
    test_errors();
    test_boundaries();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
